// File: rtl/timer_apb_pkg.sv
// Shared types and constants for the timer APB command master.
// The optional ACCESS timeout is built only when APB_TIMEOUT_EN is defined.
package timer_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int DEF_ADDR_W      = 12;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 16;

    // Timer register map
    localparam logic [11:0] ADDR_TCR   = 12'h000;
    localparam logic [11:0] ADDR_TDR0  = 12'h004;
    localparam logic [11:0] ADDR_TDR1  = 12'h008;
    localparam logic [11:0] ADDR_TCMP0 = 12'h00C;
    localparam logic [11:0] ADDR_TCMP1 = 12'h010;
    localparam logic [11:0] ADDR_TIER  = 12'h014;
    localparam logic [11:0] ADDR_TISR  = 12'h018;
    localparam logic [11:0] ADDR_THCSR = 12'h01C;

endpackage

// File: rtl/timer_apb_master_if.sv
// Command/response channel plus the tim_p* APB bus of the timer master.
interface timer_apb_master_if
    import timer_apb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_strb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  tim_psel;
    logic                  tim_penable;
    logic                  tim_pwrite;
    logic [ADDR_W-1:0]     tim_paddr;
    logic [DATA_W-1:0]     tim_pwdata;
    logic [DATA_W/8-1:0]   tim_pstrb;
    logic [DATA_W-1:0]     tim_prdata;
    logic                  tim_pready;
    logic                  tim_pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
        input  tim_prdata, tim_pready, tim_pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
        output tim_prdata, tim_pready, tim_pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog: counts stalled ACCESS cycles and flags the last allowed one.
// Present only when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_r;

    // Expire on the TIMEOUT_CYC-th stalled cycle so the abort lands at its end
    assign expire = enable && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

    // Stall counter: cleared at SETUP, advanced while ACCESS waits for pready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule
`endif

// File: rtl/timer_apb_master.sv
// Command-to-APB master for timer_top: one valid/ready command becomes one
// SETUP/ACCESS transfer; the result is returned on a valid/ready response channel.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC stalled cycles.
module timer_apb_master
    import timer_apb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef APB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    timer_apb_master_if.master  bus
);
    localparam int STRB_W = DATA_W / 8;

    apb_state_e         state_r;
    logic               cmd_ready_r;
    logic               psel_r;
    logic               penable_r;
    logic               pwrite_r;
    logic [ADDR_W-1:0]  paddr_r;
    logic [DATA_W-1:0]  pwdata_r;
    logic [STRB_W-1:0]  pstrb_r;
    logic               rsp_valid_r;
    logic [DATA_W-1:0]  rsp_rdata_r;
    logic               rsp_err_r;

`ifdef APB_TIMEOUT_EN
    logic               rsp_timeout_r;
    logic               expire_s;

    apb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .clear  (state_r == ST_SETUP),
        .enable ((state_r == ST_ACCESS) && !bus.tim_pready),
        .expire (expire_s)
    );

    assign bus.rsp_timeout = rsp_timeout_r;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    assign bus.cmd_ready   = cmd_ready_r;
    assign bus.tim_psel    = psel_r;
    assign bus.tim_penable = penable_r;
    assign bus.tim_pwrite  = pwrite_r;
    assign bus.tim_paddr   = paddr_r;
    assign bus.tim_pwdata  = pwdata_r;
    assign bus.tim_pstrb   = pstrb_r;
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_err     = rsp_err_r;

    // Transfer FSM with all bus and response outputs registered
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r       <= ST_IDLE;
            cmd_ready_r   <= 1'b0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= {ADDR_W{1'b0}};
            pwdata_r      <= {DATA_W{1'b0}};
            pstrb_r       <= {STRB_W{1'b0}};
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {DATA_W{1'b0}};
            rsp_err_r     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            rsp_timeout_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        // Reads drive zero data and strobes onto the bus
                        state_r     <= ST_SETUP;
                        cmd_ready_r <= 1'b0;
                        psel_r      <= 1'b1;
                        pwrite_r    <= bus.cmd_write;
                        paddr_r     <= bus.cmd_addr;
                        pwdata_r    <= bus.cmd_write ? bus.cmd_wdata : {DATA_W{1'b0}};
                        pstrb_r     <= bus.cmd_write ? bus.cmd_strb  : {STRB_W{1'b0}};
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_r   <= ST_ACCESS;
                    penable_r <= 1'b1;
                end
                ST_ACCESS: begin
                    if (bus.tim_pready) begin
                        state_r     <= ST_RESP;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        pwrite_r    <= 1'b0;
                        paddr_r     <= {ADDR_W{1'b0}};
                        pwdata_r    <= {DATA_W{1'b0}};
                        pstrb_r     <= {STRB_W{1'b0}};
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= pwrite_r ? {DATA_W{1'b0}} : bus.tim_prdata;
                        rsp_err_r   <= bus.tim_pslverr;
`ifdef APB_TIMEOUT_EN
                    end else if (expire_s) begin
                        // Slave never answered: drop the bus and report a timeout
                        state_r       <= ST_RESP;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        pwrite_r      <= 1'b0;
                        paddr_r       <= {ADDR_W{1'b0}};
                        pwdata_r      <= {DATA_W{1'b0}};
                        pstrb_r       <= {STRB_W{1'b0}};
                        rsp_valid_r   <= 1'b1;
                        rsp_rdata_r   <= {DATA_W{1'b0}};
                        rsp_err_r     <= 1'b1;
                        rsp_timeout_r <= 1'b1;
`endif
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state_r       <= ST_IDLE;
                        cmd_ready_r   <= 1'b1;
                        rsp_valid_r   <= 1'b0;
                        rsp_rdata_r   <= {DATA_W{1'b0}};
                        rsp_err_r     <= 1'b0;
`ifdef APB_TIMEOUT_EN
                        rsp_timeout_r <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cmd_ready_r <= 1'b0;
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
